// File: rtl/alu_issue.sv
// alu_issue: operand-issue stage with 32x32 register file, write-back bypass and registered ALU bundle
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [3:0]  mode,
  output logic [4:0]  rd,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] issue_count
);
  logic [31:0] regs [32];
  logic [4:0]  rs1, rs2;
  logic [31:0] rs1_val, rs2_val, b_val;
  logic        wb_hit, accept;
  assign rs1     = in_instr[13:9];
  assign rs2     = in_instr[18:14];
  assign wb_hit  = wb_en && wb_rd != 5'd0;
  assign rs1_val = rs1 == 5'd0 ? 32'd0 : (wb_hit && wb_rd == rs1) ? wb_data : regs[rs1];
  assign rs2_val = rs2 == 5'd0 ? 32'd0 : (wb_hit && wb_rd == rs2) ? wb_data : regs[rs2];
  assign b_val   = in_instr[19] ? {{20{in_instr[31]}}, in_instr[31:20]} : rs2_val;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (wb_hit) begin
      regs[wb_rd] <= wb_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      A           <= 32'd0;
      B           <= 32'd0;
      mode        <= 4'd0;
      rd          <= 5'd0;
      issue_count <= 32'd0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      A           <= rs1_val;
      B           <= b_val;
      mode        <= in_instr[3:0];
      rd          <= in_instr[8:4];
      issue_count <= issue_count + 32'd1;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed self-checking bench for alu_issue
module tb_alu_issue;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, wb_en;
  logic [31:0] in_instr, A, B, wb_data, issue_count;
  logic [3:0]  mode;
  logic [4:0]  rd, wb_rd;
  int checks = 0;
  int fails  = 0;

  alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .A(A), .B(B), .mode(mode), .rd(rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [3:0] m, input logic [4:0] d, input logic [4:0] s1,
                                      input logic [4:0] s2, input logic u, input logic [11:0] im);
    return {im, u, s2, s1, d, m};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    in_instr = enc(4'd9, 5'd3, 5'd0, 5'd0, 1'b1, 12'h123);
    step(); step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, A, B, mode, rd, issue_count} !== {1'b0, 32'd0, 32'd0, 4'd0, 5'd0, 32'd0}) begin
      fails++;
      $display("FAIL reset_state: got v=%b A=%h B=%h mode=%h rd=%h cnt=%0d, expected all zero", out_valid, A, B, mode, rd, issue_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_load();
    wb_write(5'd1, 32'h1);
    wb_write(5'd2, 32'h2);
    in_valid = 1'b1; out_ready = 1'b0;
    in_instr = enc(4'd1, 5'd3, 5'd1, 5'd2, 1'b0, 12'h0);
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, A, B, mode, rd, issue_count} !== {1'b1, 32'h1, 32'h2, 4'd1, 5'd3, 32'd1}) begin
      fails++;
      $display("FAIL load: got v=%b A=%h B=%h mode=%h rd=%h cnt=%0d, expected 1/1/2/1/3/1", out_valid, A, B, mode, rd, issue_count);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL drain: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_imm();
    in_valid = 1'b1; out_ready = 1'b1;
    in_instr = enc(4'd2, 5'd6, 5'd1, 5'd2, 1'b1, 12'hFFF);
    step();
    checks++;
    if ({A, B} !== {32'h1, 32'hFFFF_FFFF}) begin
      fails++; $display("FAIL imm_neg: got A=%h B=%h expected 00000001 ffffffff", A, B);
    end
    in_instr = enc(4'd2, 5'd6, 5'd1, 5'd2, 1'b1, 12'h020);
    step();
    in_valid = 1'b0;
    checks++;
    if ({B, out_valid, issue_count} !== {32'h20, 1'b1, 32'd3}) begin
      fails++; $display("FAIL imm_pos: got B=%h v=%b cnt=%0d expected 00000020 1 3", B, out_valid, issue_count);
    end
    step();
  endtask

  task automatic test_bypass();
    in_valid = 1'b1; out_ready = 1'b0;
    in_instr = enc(4'd2, 5'd4, 5'd1, 5'd2, 1'b0, 12'h0);
    step();
    out_ready = 1'b1; wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'hA;
    in_instr = enc(4'd3, 5'd5, 5'd4, 5'd0, 1'b0, 12'h0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bypass_ready: got %b expected 1", in_ready); end
    step();
    wb_en = 1'b0;
    checks++;
    if ({out_valid, A, B, mode, rd, issue_count} !== {1'b1, 32'hA, 32'd0, 4'd3, 5'd5, 32'd5}) begin
      fails++;
      $display("FAIL bypass: got v=%b A=%h B=%h mode=%h rd=%h cnt=%0d expected 1/a/0/3/5/5", out_valid, A, B, mode, rd, issue_count);
    end
    in_instr = enc(4'd4, 5'd6, 5'd0, 5'd4, 1'b0, 12'h0);
    step();
    checks++;
    if ({A, B, issue_count} !== {32'd0, 32'hA, 32'd6}) begin
      fails++; $display("FAIL regfile_r4: got A=%h B=%h cnt=%0d expected 0 a 6", A, B, issue_count);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = enc(4'd5, 5'd7, 5'd1, 5'd2, 1'b0, 12'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_ready[%0d]: got %b expected 0", i, in_ready); end
      step();
      checks++;
      if ({out_valid, A, B, mode, rd, issue_count} !== {1'b1, 32'd0, 32'hA, 4'd4, 5'd6, 32'd6}) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got v=%b A=%h B=%h mode=%h rd=%h cnt=%0d expected 1/0/a/4/6/6", i, out_valid, A, B, mode, rd, issue_count);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL unstall_ready: got %b expected 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, A, B, mode, rd, issue_count} !== {1'b1, 32'h1, 32'h2, 4'd5, 5'd7, 32'd7}) begin
      fails++;
      $display("FAIL unstall_accept: got v=%b A=%h B=%h mode=%h rd=%h cnt=%0d expected 1/1/2/5/7/7", out_valid, A, B, mode, rd, issue_count);
    end
    step();
  endtask

  task automatic test_r0_reset();
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD_BEEF;
    in_valid = 1'b1; out_ready = 1'b1;
    in_instr = enc(4'd1, 5'd2, 5'd0, 5'd0, 1'b0, 12'h0);
    step();
    wb_en = 1'b0;
    checks++;
    if ({A, B} !== 64'd0) begin fails++; $display("FAIL r0_bypass: got A=%h B=%h expected 0 0", A, B); end
    step();
    checks++;
    if ({out_valid, A} !== {1'b1, 32'd0}) begin fails++; $display("FAIL r0_read: got v=%b A=%h expected 1 0", out_valid, A); end
    rst = 1'b1; out_ready = 1'b0; wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
    in_instr = enc(4'd1, 5'd2, 5'd1, 5'd0, 1'b0, 12'h0);
    step();
    rst = 1'b0; wb_en = 1'b0; in_valid = 1'b0;
    checks++;
    if ({out_valid, A, issue_count} !== {1'b0, 32'd0, 32'd0}) begin
      fails++; $display("FAIL mid_reset: got v=%b A=%h cnt=%0d expected 0 0 0", out_valid, A, issue_count);
    end
    in_valid = 1'b1; out_ready = 1'b1;
    in_instr = enc(4'd1, 5'd2, 5'd1, 5'd2, 1'b0, 12'h0);
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, A, B, issue_count} !== {1'b1, 32'd0, 32'd0, 32'd1}) begin
      fails++; $display("FAIL regs_cleared: got v=%b A=%h B=%h cnt=%0d expected 1 0 0 1", out_valid, A, B, issue_count);
    end
    step();
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wb_write(5'd1, 32'hA);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int m = 1; m <= 7; m++) begin
      in_instr = enc(4'(m), 5'(m + 8), 5'd1, 5'd0, 1'b1, 12'h020);
      step();
      checks++;
      if ({out_valid, A, B, mode, rd} !== {1'b1, 32'hA, 32'h20, 4'(m), 5'(m + 8)}) begin
        fails++;
        $display("FAIL sweep[%0d]: got v=%b A=%h B=%h mode=%h rd=%h expected 1/a/20/%0h/%0h", m, out_valid, A, B, mode, rd, m, m + 8);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (issue_count !== 32'd7) begin fails++; $display("FAIL sweep_count: got %0d expected 7", issue_count); end
    step();
    checks++;
    if ({out_valid, issue_count} !== {1'b0, 32'd7}) begin
      fails++; $display("FAIL sweep_drain: got v=%b cnt=%0d expected 0 7", out_valid, issue_count);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_imm();
    test_bypass();
    test_stall();
    test_r0_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
